pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Parametrised program-counter unit for the fetch stage of the 32-bit ARM core, replacing the plain clocked PC register. Holds the fetch address, generates the sequential next address internally, and applies stall, branch redirect and exception redirect with fixed priority. Presents the fetch address to instruction memory with a valid/ready handshake and provides PC+STEP and the ARM-visible PC+PIPE_OFFSET. Keeps a saturating accepted-fetch counter for performance monitoring.

## Interface
- ADDR_W, 32: PC and target width.
- RESET_VECTOR, 0: PC value on reset.
- EXC_VECTOR, 32'h0000_0004: exception redirect address.
- STEP, 4: sequential increment in bytes; power of two, at least 1.
- PIPE_OFFSET, 8: offset added for the architectural PC read value.
- CNT_W, 16: fetch counter width.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- stall_i  in  1  hold PC; ignored when a redirect is present.
- branch_valid_i  in  1  branch redirect request, single-cycle.
- branch_target_i  in  ADDR_W  branch target.
- exc_req_i  in  1  exception redirect request, single-cycle.
- imem_ready_i  in  1  instruction memory accepts pc_o this cycle.
- pc_o  out  ADDR_W  current fetch address.
- pc_valid_o  out  1  pc_o is a valid fetch request.
- pc_plus_step_o  out  ADDR_W  pc_o + STEP, combinational from the PC register.
- pc_read_o  out  ADDR_W  pc_o + PIPE_OFFSET, combinational.
- align_fault_o  out  1  one-cycle pulse: accepted branch target was misaligned.
- fetch_cnt_o  out  CNT_W  accepted fetches, saturating.

## Operation
- FSM states: BOOT and RUN. Reset enters BOOT.
- BOOT:
  - pc_valid_o = 0 and pc_o = RESET_VECTOR.
  - Next cycle goes to RUN unconditionally.
  - A redirect in BOOT is applied: PC loads the target and state goes to RUN.
- RUN:
  - pc_valid_o = 1.
  - accept = pc_valid_o & imem_ready_i & ~stall_i.
- Next-PC priority, highest first:
  1. exc_req_i: PC loads EXC_VECTOR.
  2. branch_valid_i: PC loads branch_target_i with the low log2(STEP) bits cleared.
  3. accept: PC loads pc_o + STEP.
  4. Otherwise PC holds.
- Redirect rules:
  - Redirects override stall_i and do not wait for imem_ready_i. The in-flight request is abandoned.
  - An exception and a branch in the same cycle: the exception wins and the branch is dropped. No align_fault_o is raised.
  - align_fault_o is asserted the cycle after a branch is taken whose target has a nonzero low log2(STEP) bit.
- Arithmetic is modulo 2^ADDR_W. PC = 2^ADDR_W − STEP advances to 0. pc_plus_step_o and pc_read_o wrap the same way.
- fetch_cnt_o increments on each accept and saturates at 2^CNT_W − 1.
- A redirect cycle does not count, even when imem_ready_i is high.

## Timing
- Reset values:
  - pc_o = RESET_VECTOR, pc_valid_o = 0.
  - pc_plus_step_o = RESET_VECTOR + STEP, pc_read_o = RESET_VECTOR + PIPE_OFFSET.
  - align_fault_o = 0, fetch_cnt_o = 0, state = BOOT.
- Reset is asynchronous: outputs take reset values immediately on assertion, including mid-stall or mid-redirect. No pending request survives reset.
- The first valid fetch, at RESET_VECTOR, appears one cycle after reset deasserts.
- Redirect latency is 1 cycle: the target appears on pc_o the cycle after the request.
- While not accepted and no redirect is present, pc_o is held stable.
- Sequential throughput is one address per cycle while imem_ready_i = 1 and stall_i = 0.

## Structure
- Shared package pc_pkg holds:
  - pc_state_t enum {BOOT, RUN}.
  - Default constants: PC_RESET_VECTOR, PC_EXC_VECTOR, PC_STEP, PC_PIPE_OFFSET.
- Single module with no sub-module. The saturating counter is inline and does not warrant its own module.
- Parameter check at elaboration: STEP must be a power of two.

## Test plan
- Reset release with imem_ready_i = 1 and no stall → pc_valid_o = 0 for one cycle, then pc_o = 0x0, 0x4, 0x8 on consecutive cycles. pc_read_o = 0x8 when pc_o = 0x0. fetch_cnt_o counts 1, 2, 3.
- Stall for 3 cycles at pc_o = 0x10, then imem_ready_i low for 2 cycles → pc_o holds 0x10 with no count change; advances to 0x14 on the first accept.
- branch_valid_i with target 0x102 while stalled → pc_o = 0x100 next cycle and align_fault_o pulses once. The redirect cycle is not counted.
- exc_req_i and branch_valid_i (target 0x200) in the same cycle → pc_o = 0x4 and align_fault_o = 0.
- Set pc_o = 0xFFFF_FFFC via branch, then accept → pc_o = 0x0000_0000. With CNT_W = 2, after 5 accepts fetch_cnt_o = 3.
- Assert rst mid-redirect and mid-stall → pc_o = 0x0 and pc_valid_o = 0 immediately. The BOOT cycle repeats after release.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and default constants for the fetch-stage program counter.
package pc_pkg;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } pc_state_t;

    localparam int unsigned PC_ADDR_W       = 32;
    localparam int unsigned PC_CNT_W        = 16;
    localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] PC_EXC_VECTOR   = 32'h0000_0004;
    localparam int unsigned PC_STEP         = 4;
    localparam int unsigned PC_PIPE_OFFSET  = 8;

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC: sequential advance, stall, branch/exception redirect,
// valid/ready fetch handshake and a saturating accepted-fetch counter.
module pc_fetch_unit
    import pc_pkg::*;
#(
    parameter int unsigned       ADDR_W       = PC_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(PC_RESET_VECTOR),
    parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(PC_EXC_VECTOR),
    parameter int unsigned       STEP         = PC_STEP,
    parameter int unsigned       PIPE_OFFSET  = PC_PIPE_OFFSET,
    parameter int unsigned       CNT_W        = PC_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              branch_valid_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic              exc_req_i,
    input  logic              imem_ready_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              pc_valid_o,
    output logic [ADDR_W-1:0] pc_plus_step_o,
    output logic [ADDR_W-1:0] pc_read_o,
    output logic              align_fault_o,
    output logic [CNT_W-1:0]  fetch_cnt_o
);

    localparam logic [ADDR_W-1:0] STEP_V     = ADDR_W'(STEP);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STEP - 1);
    localparam logic [ADDR_W-1:0] OFFSET_V   = ADDR_W'(PIPE_OFFSET);

    if (!is_pow2(STEP)) begin : g_step_chk
        $error("pc_fetch_unit: STEP must be a power of two");
    end

    pc_state_t         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              valid_q, valid_d;
    logic              fault_q, fault_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept;
    logic              redirect;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: exception > branch > accepted advance > hold.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        fault_d  = 1'b0;
        cnt_d    = cnt_q;
        accept   = valid_q & imem_ready_i & ~stall_i;
        redirect = exc_req_i | branch_valid_i;

        unique case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = BOOT;
        endcase

        if (exc_req_i) begin
            pc_d = EXC_VECTOR;
        end else if (branch_valid_i) begin
            pc_d    = branch_target_i & ~ALIGN_MASK;
            fault_d = |(branch_target_i & ALIGN_MASK);
        end else if (accept) begin
            pc_d = pc_q + STEP_V;
        end

        // Redirect cycles abandon the in-flight request, so they never count.
        if (accept && !redirect && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        valid_d = (state_d == RUN);
    end

    assign pc_o           = pc_q;
    assign pc_valid_o     = valid_q;
    assign pc_plus_step_o = pc_q + STEP_V;
    assign pc_read_o      = pc_q + OFFSET_V;
    assign align_fault_o  = fault_q;
    assign fetch_cnt_o    = cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed steps plus random traffic
// against a behavioural model; a second instance exercises a 2-bit counter.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        branch_valid_i;
    logic [31:0] branch_target_i;
    logic        exc_req_i;
    logic        imem_ready_i;

    logic [31:0] pc_o, pc_plus_step_o, pc_read_o;
    logic        pc_valid_o, align_fault_o;
    logic [15:0] fetch_cnt_o;

    logic [31:0] pc2_o, pc2_plus_step_o, pc2_read_o;
    logic        pc2_valid_o, align2_fault_o;
    logic [1:0]  fetch2_cnt_o;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    bit          m_boot;
    logic [31:0] m_pc;
    bit          m_fault;
    int          m_cnt;

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .clk(clk), .rst(rst), .stall_i(stall_i),
        .branch_valid_i(branch_valid_i), .branch_target_i(branch_target_i),
        .exc_req_i(exc_req_i), .imem_ready_i(imem_ready_i),
        .pc_o(pc_o), .pc_valid_o(pc_valid_o), .pc_plus_step_o(pc_plus_step_o),
        .pc_read_o(pc_read_o), .align_fault_o(align_fault_o), .fetch_cnt_o(fetch_cnt_o)
    );

    pc_fetch_unit #(.CNT_W(2)) dut_c2 (
        .clk(clk), .rst(rst), .stall_i(stall_i),
        .branch_valid_i(branch_valid_i), .branch_target_i(branch_target_i),
        .exc_req_i(exc_req_i), .imem_ready_i(imem_ready_i),
        .pc_o(pc2_o), .pc_valid_o(pc2_valid_o), .pc_plus_step_o(pc2_plus_step_o),
        .pc_read_o(pc2_read_o), .align_fault_o(align2_fault_o), .fetch_cnt_o(fetch2_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sat(input int v, input int maxv);
        return (v > maxv) ? 32'(maxv) : 32'(v);
    endfunction

    task automatic check_model();
        chk("pc",         pc_o,                  m_pc);
        chk("valid",      {31'b0, pc_valid_o},   {31'b0, !m_boot});
        chk("plus_step",  pc_plus_step_o,        m_pc + 32'd4);
        chk("pc_read",    pc_read_o,             m_pc + 32'd8);
        chk("align",      {31'b0, align_fault_o}, {31'b0, m_fault});
        chk("cnt16",      {16'b0, fetch_cnt_o},  sat(m_cnt, 65535));
        chk("cnt2",       {30'b0, fetch2_cnt_o}, sat(m_cnt, 3));
        chk("pc_inst2",   pc2_o,                 m_pc);
    endtask

    // Called right after a negedge: drive, check, clock, update model.
    task automatic step(input bit st, input bit br, input logic [31:0] tgt,
                        input bit ex, input bit rdy);
        bit acc;
        stall_i = st; branch_valid_i = br; branch_target_i = tgt;
        exc_req_i = ex; imem_ready_i = rdy;
        check_model();
        acc = !m_boot && rdy && !st;
        @(posedge clk);
        if (ex) begin
            m_pc = 32'h4;
            m_fault = 1'b0;
        end else if (br) begin
            m_pc = tgt - (tgt % 32'd4);
            m_fault = (tgt % 32'd4) != 0;
        end else begin
            if (acc) m_pc = m_pc + 32'd4;
            m_fault = 1'b0;
        end
        if (acc && !ex && !br) m_cnt++;
        m_boot = 1'b0;
        @(negedge clk);
    endtask

    // Called right after a negedge: present inputs, then assert reset mid-cycle.
    task automatic do_reset(input bit st, input bit br, input logic [31:0] tgt, input bit ex);
        stall_i = st; branch_valid_i = br; branch_target_i = tgt;
        exc_req_i = ex; imem_ready_i = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("rst_pc",        pc_o,                   32'h0);
        chk("rst_valid",     {31'b0, pc_valid_o},    32'h0);
        chk("rst_plus_step", pc_plus_step_o,         32'h4);
        chk("rst_read",      pc_read_o,              32'h8);
        chk("rst_align",     {31'b0, align_fault_o}, 32'h0);
        chk("rst_cnt",       {16'b0, fetch_cnt_o},   32'h0);
        @(negedge clk);
        rst = 1'b0;
        stall_i = 1'b0; branch_valid_i = 1'b0; exc_req_i = 1'b0;
        m_boot = 1'b1; m_pc = 32'h0; m_fault = 1'b0; m_cnt = 0;
    endtask

    initial begin
        rst = 1'b1;
        stall_i = 1'b0; branch_valid_i = 1'b0; branch_target_i = '0;
        exc_req_i = 1'b0; imem_ready_i = 1'b1;
        @(negedge clk);
        do_reset(1'b0, 1'b0, 32'h0, 1'b0);

        // Boot cycle, then sequential fetch 0x0, 0x4, 0x8, 0xC
        repeat (5) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("seq_pc", pc_o, 32'h10);
        chk("seq_cnt", {16'b0, fetch_cnt_o}, 32'd4);

        // Stall then memory not ready: hold without counting
        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        repeat (2) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("hold_pc", pc_o, 32'h10);
        chk("hold_cnt", {16'b0, fetch_cnt_o}, 32'd4);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("adv_pc", pc_o, 32'h14);

        // Misaligned branch while stalled
        step(1'b1, 1'b1, 32'h102, 1'b0, 1'b1);
        chk("br_pc", pc_o, 32'h100);
        chk("br_fault", {31'b0, align_fault_o}, 32'h1);
        chk("br_cnt", {16'b0, fetch_cnt_o}, 32'd5);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("br_fault_pulse", {31'b0, align_fault_o}, 32'h0);

        // Exception beats branch
        step(1'b0, 1'b1, 32'h201, 1'b1, 1'b1);
        chk("exc_pc", pc_o, 32'h4);
        chk("exc_fault", {31'b0, align_fault_o}, 32'h0);

        // Wrap at top of address space
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
        chk("top_plus_step", pc_plus_step_o, 32'h0);
        chk("top_read", pc_read_o, 32'h4);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("wrap_pc", pc_o, 32'h0);

        // Saturation of the 2-bit counter after 5 accepts
        do_reset(1'b0, 1'b0, 32'h0, 1'b0);
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("sat_cnt2", {30'b0, fetch2_cnt_o}, 32'd3);
        chk("sat_cnt16", {16'b0, fetch_cnt_o}, 32'd5);

        // Reset during a redirect under stall; boot cycle repeats
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        do_reset(1'b1, 1'b1, 32'h300, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            bit          st, br, ex, rdy;
            logic [31:0] tgt;
            st  = ($urandom_range(0, 3) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            br  = ($urandom_range(0, 9) == 0);
            ex  = ($urandom_range(0, 19) == 0);
            tgt = $urandom;
            if ($urandom_range(0, 1) == 0) tgt[1:0] = 2'b00;
            if ($urandom_range(0, 59) == 0) do_reset(st, br, tgt, ex);
            else step(st, br, tgt, ex, rdy);
        end
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
